pll_lock_supervisor: RTL

- Parametrised supervisor for up to NUM_PLL iCE40 SB_PLL40 instances (PAD / CORE / 2F variants).
- Drives each PLL's RESETB and monitors its LOCK.
- Releases a single system reset only after every enabled PLL has held lock continuously for a programmable time.
- Re-runs the lock sequence on lock loss, retries on timeout, and latches a fault after repeated failure. Sits beside the PLL wrappers in the top level.

---
 rtl/pll_lock_supervisor.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// Sequences reset and lock qualification for a bank of iCE40 PLLs and
// releases the system reset once every enabled PLL has held lock long enough.
module pll_lock_supervisor #(
  parameter int NUM_PLL             = 2,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               clock_in,
  input  logic               resetn,
  input  logic [NUM_PLL-1:0] pll_enable,
  input  logic [NUM_PLL-1:0] lock_in,
  input  logic               retry_req,
  output logic [NUM_PLL-1:0] pll_resetb,
  output logic               sys_resetn,
  output logic               all_locked,
  output logic               fault,
  output logic [3:0]         retry_count,
  output logic [7:0]         loss_count
);

  localparam int MAX_HT = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                          RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P  = (MAX_HT > LOCK_STABLE_CYCLES) ? MAX_HT : LOCK_STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [NUM_PLL-1:0] en_reg;
  logic [NUM_PLL-1:0] sync_meta;
  logic [NUM_PLL-1:0] lock_s;
  logic [NUM_PLL-1:0] ok_bits;
  logic               locks_ok;
  logic               en_changed;
  logic [3:0]         retry_inc;

  // lock_in is asynchronous to clock_in; two flops before any decision uses it.
  always_ff @(posedge clock_in) begin
    if (!resetn) begin
      sync_meta <= '0;
      lock_s    <= '0;
    end else begin
      sync_meta <= lock_in;
      lock_s    <= sync_meta;
    end
  end

  for (genvar gi = 0; gi < NUM_PLL; gi++) begin : g_ok
    assign ok_bits[gi] = lock_s[gi] | ~en_reg[gi];
  end

  assign locks_ok   = &ok_bits;
  assign en_changed = (pll_enable != en_reg);
  assign retry_inc  = retry_count + 4'd1;

  always_ff @(posedge clock_in) begin
    if (!resetn) begin
      state_reg   <= S_HOLD;
      count_reg   <= '0;
      en_reg      <= '0;
      pll_resetb  <= '0;
      sys_resetn  <= 1'b0;
      all_locked  <= 1'b0;
      fault       <= 1'b0;
      retry_count <= '0;
      loss_count  <= '0;
    end else begin
      case (state_reg)
        S_HOLD: begin
          if (count_reg == HOLD_LAST) begin
            count_reg <= '0;
            // An all-zero mask keeps re-running the hold window.
            if (pll_enable != '0) begin
              en_reg     <= pll_enable;
              pll_resetb <= pll_enable;
              state_reg  <= S_WAIT_LOCK;
            end
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          if (en_changed) begin
            state_reg  <= S_HOLD;
            count_reg  <= '0;
            pll_resetb <= '0;
          end else if (locks_ok) begin
            state_reg <= S_STABLE;
            count_reg <= '0;
          end else if (count_reg == TIMEOUT_LAST) begin
            count_reg   <= '0;
            pll_resetb  <= '0;
            retry_count <= retry_inc;
            if (retry_inc == RETRY_LIMIT) begin
              state_reg <= S_FAULT;
              fault     <= 1'b1;
            end else begin
              state_reg <= S_HOLD;
            end
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        S_STABLE: begin
          if (en_changed) begin
            state_reg  <= S_HOLD;
            count_reg  <= '0;
            pll_resetb <= '0;
          end else if (!locks_ok) begin
            state_reg <= S_WAIT_LOCK;
            count_reg <= '0;
          end else if (count_reg == STABLE_LAST) begin
            state_reg   <= S_RUN;
            count_reg   <= '0;
            retry_count <= '0;
            sys_resetn  <= 1'b1;
            all_locked  <= 1'b1;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        S_RUN: begin
          // Lock loss is checked first so a coincident mask change still counts as a loss.
          if (!locks_ok || en_changed) begin
            state_reg  <= S_HOLD;
            count_reg  <= '0;
            pll_resetb <= '0;
            sys_resetn <= 1'b0;
            all_locked <= 1'b0;
            if (!locks_ok && loss_count != 8'hFF)
              loss_count <= loss_count + 8'd1;
          end
        end

        S_FAULT: begin
          if (retry_req) begin
            state_reg   <= S_HOLD;
            count_reg   <= '0;
            fault       <= 1'b0;
            retry_count <= '0;
          end
        end

        default: begin
          state_reg  <= S_HOLD;
          count_reg  <= '0;
          pll_resetb <= '0;
          sys_resetn <= 1'b0;
          all_locked <= 1'b0;
          fault      <= 1'b0;
        end
      endcase
    end
  end

endmodule
